seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexed scan and rotation controller for the 4-digit seven-segment display on the Spartan-3 board.
- Drives the 2-bit digit select `regSel` and the 4-bit message offset `rot_counter` into the 16x4 character register multiplexer.
- Drives the active-low digit anodes, with a blanking gap between digits to prevent ghosting.
- Advances the message offset once every ROT_FRAMES complete display frames, giving a scrolling display.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot (blank + drive); must be > BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be >= 1.
- ROT_FRAMES, 200: full 4-digit frames per rotation step; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = scanning active; 0 = display blanked, scan parked
- dir  input  1  rotation direction: 0 = increment `rot_counter`, 1 = decrement
- hold  input  1  1 = freeze `rot_counter` (scan continues)
- rot_counter  output  4  message offset to the character mux
- regSel  output  2  current digit index to the character mux
- an  output  4  digit anodes, active-low; an[i] = 0 lights digit i
- frame_done  output  1  one-cycle pulse at the end of each complete frame
- step  output  1  one-cycle pulse in the cycle `rot_counter` changes

Behaviour:
- Reset (async, reset = 1):
  - state = IDLE; slot counter = 0; frame counter = 0.
  - rot_counter = 0; regSel = 0; an = 4'b1111; frame_done = 0; step = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, BLANK, DRIVE.
- IDLE:
  - an = 1111.
  - enable = 1 -> BLANK next cycle, with regSel = 0 and slot counter = 0.
- BLANK:
  - an = 1111.
  - Slot counter counts 0..BLANK_CYCLES-1, then -> DRIVE.
- DRIVE:
  - an has a single 0 at bit position regSel.
  - Slot counter continues BLANK_CYCLES..REFRESH_DIV-1.
  - On the last cycle (count = REFRESH_DIV-1):
    - regSel <= regSel+1 mod 4; slot counter <= 0; -> BLANK.
- Slot timing: each digit slot is exactly REFRESH_DIV cycles.
  - Anode low for REFRESH_DIV-BLANK_CYCLES cycles per slot.
  - Frame period = 4*REFRESH_DIV cycles.
- Frame wrap: the DRIVE end cycle with regSel = 3.
  - frame_done = 1 for one cycle, registered, coincident with regSel returning to 0.
  - Frame counter increments. When it is at ROT_FRAMES-1, it resets to 0 and a rotation event occurs.
- Rotation event:
  - dir and hold are sampled on the wrap cycle only.
  - hold = 1: rot_counter unchanged, step = 0. The frame counter still resets.
  - hold = 0: rot_counter <= rot_counter+1 (dir = 0) or rot_counter-1 (dir = 1), 4-bit modulo (15+1 -> 0, 0-1 -> 15); step = 1 for one cycle.
- rot_counter changes only at frame boundaries; a frame never shows mixed offsets.
- The character mux adds regSel to rot_counter itself; this block outputs them separately and never sums them.
- enable deasserted in BLANK or DRIVE:
  - -> IDLE next cycle; an = 1111 in that same cycle.
  - regSel <= 0; slot counter <= 0.
  - rot_counter and frame counter are retained.
  - No frame_done or step is issued, even if that cycle would have been the wrap.
- enable reasserted: a fresh frame starts at digit 0 with a full BLANK period.
- reset asserted mid-slot: immediate async return to the reset values. After release, a scan starts on the first clk edge where enable = 1.
- At most one anode is low at any time; an = 1111 in every BLANK cycle.

Test Plan:
- Test parameters for all scenarios: REFRESH_DIV = 8, BLANK_CYCLES = 2, ROT_FRAMES = 3.
- Reset then enable = 1 from cycle 0:
  - Expect an = 1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2, then 1101 for 6, and so on.
  - regSel sequence 0,1,2,3,0; frame_done pulses every 32 cycles.
- dir = 0, hold = 0 for 9 frames:
  - step pulses at frames 3, 6 and 9; rot_counter goes 0 -> 1 -> 2 -> 3.
  - rot_counter changes only on the cycle where regSel goes 3 -> 0.
- Preload rot_counter to 15 by running 45 frames, then 3 more frames:
  - rot_counter wraps to 0.
  - Then set dir = 1 for 3 frames: rot_counter goes 0 -> 15.
- hold = 1 across a rotation wrap:
  - frame_done still pulses; step = 0; rot_counter unchanged.
  - The frame counter restarts, so the next step comes 3 frames after the hold is released.
- enable = 0 in DRIVE of digit 2 (an = 1011):
  - Next cycle an = 1111, regSel = 0, no frame_done.
  - Reassert enable: 2 blank cycles, then an = 1110; rot_counter unchanged.
- reset = 1 asynchronously mid-DRIVE with rot_counter = 5:
  - Outputs go to rot_counter = 0, regSel = 0, an = 1111, step = frame_done = 0 without waiting for a clk edge.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Scan and rotation controller for a 4-digit multiplexed seven-segment display.
// Blanks each digit slot briefly to avoid ghosting and steps the message offset every ROT_FRAMES frames.
module seg_scan_controller #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ROT_FRAMES   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir,
    input  logic       hold,
    output logic [3:0] rot_counter,
    output logic [1:0] regSel,
    output logic [3:0] an,
    output logic       frame_done,
    output logic       step
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRAME_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ROT_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         rot_q, rot_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         an_q, an_d;
    logic               frame_done_q, frame_done_d;
    logic               step_q, step_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            frame_q      <= '0;
            rot_q        <= 4'd0;
            sel_q        <= 2'd0;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_q      <= frame_d;
            rot_q        <= rot_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            step_q       <= step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_d      = frame_q;
        rot_d        = rot_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        step_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_BLANK;
                    slot_d  = '0;
                    sel_d   = 2'd0;
                end
            end

            ST_BLANK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    sel_d   = 2'd0;
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                    if (slot_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                    end
                end
            end

            ST_DRIVE: begin
                if (!enable) begin
                    // Dropping enable abandons the frame: no wrap pulses, offset and frame count kept.
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    sel_d   = 2'd0;
                end else if (slot_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    slot_d  = '0;
                    sel_d   = sel_q + 2'd1;
                    if (sel_q == 2'd3) begin
                        frame_done_d = 1'b1;
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            if (!hold) begin
                                step_d = 1'b1;
                                rot_d  = dir ? (rot_q - 4'd1) : (rot_q + 4'd1);
                            end
                        end else begin
                            frame_d = frame_q + FRAME_ONE;
                        end
                    end
                end else begin
                    slot_d = slot_q + SLOT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
                sel_d   = 2'd0;
            end
        endcase

        // Anodes follow the next state so the registered copy lines up with state_q.
        an_d = (state_d == ST_DRIVE) ? ~(4'b0001 << sel_d) : 4'b1111;
    end

    assign rot_counter = rot_q;
    assign regSel      = sel_q;
    assign an          = an_q;
    assign frame_done  = frame_done_q;
    assign step        = step_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a frame-position reference model and expected-value queue.
module tb_seg_scan_controller;

    localparam int R = 8;
    localparam int B = 2;
    localparam int F = 3;
    localparam int FRAME_LEN = 4 * R;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       hold;
    logic [3:0] rot_counter;
    logic [1:0] regSel;
    logic [3:0] an;
    logic       frame_done;
    logic       step;

    seg_scan_controller #(
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B),
        .ROT_FRAMES  (F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .hold       (hold),
        .rot_counter(rot_counter),
        .regSel     (regSel),
        .an         (an),
        .frame_done (frame_done),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [1:0] sel;
        logic [3:0] rot;
        logic       fd;
        logic       st;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cnt_step = 0;
    int cnt_fd = 0;

    bit         m_active;
    int         m_pos;
    int         m_fc;
    logic [3:0] m_rot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_fc     = 0;
        m_rot    = 4'd0;
    endtask

    // One clock: advance the model on the current inputs, queue the expectation, compare after the edge.
    task automatic tick();
        exp_t       e;
        exp_t       got;
        logic [3:0] one_hot;
        e.fd = 1'b0;
        e.st = 1'b0;
        if (!m_active) begin
            if (enable) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else if (!enable) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (m_pos == FRAME_LEN - 1) begin
            m_pos = 0;
            e.fd  = 1'b1;
            m_fc++;
            if (m_fc == F) begin
                m_fc = 0;
                if (!hold) begin
                    e.st  = 1'b1;
                    m_rot = dir ? m_rot - 4'd1 : m_rot + 4'd1;
                end
            end
        end else begin
            m_pos++;
        end
        one_hot = 4'b0001 << (m_pos / R);
        e.an  = (m_active && (m_pos % R) >= B) ? ~one_hot : 4'b1111;
        e.sel = m_active ? 2'(m_pos / R) : 2'd0;
        e.rot = m_rot;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {an, regSel, rot_counter, frame_done, step};
        check("cycle", 32'(got), 32'(e));
        if (step) cnt_step++;
        if (frame_done) cnt_fd++;
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME_LEN) tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        dir    = 1'b0;
        hold   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_sel", 32'(regSel), 32'h0);
        check("rst_rot", 32'(rot_counter), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        reset = 1'b0;

        tick();
        enable = 1'b1;
        tick();
        check("first_blank_an", 32'(an), 32'hF);

        // Nine frames incrementing: three steps, offset 3.
        cnt_step = 0;
        cnt_fd   = 0;
        run_frames(9);
        check("inc_steps", 32'(cnt_step), 32'd3);
        check("inc_frames", 32'(cnt_fd), 32'd9);
        check("inc_rot", 32'(rot_counter), 32'd3);

        run_frames(36);
        check("rot_at_15", 32'(rot_counter), 32'd15);
        run_frames(3);
        check("rot_wrap_up", 32'(rot_counter), 32'd0);

        dir = 1'b1;
        run_frames(3);
        check("rot_wrap_down", 32'(rot_counter), 32'd15);

        // Hold across a rotation boundary, then release.
        hold     = 1'b1;
        cnt_step = 0;
        cnt_fd   = 0;
        run_frames(3);
        check("hold_steps", 32'(cnt_step), 32'd0);
        check("hold_frames", 32'(cnt_fd), 32'd3);
        check("hold_rot", 32'(rot_counter), 32'd15);
        hold     = 1'b0;
        cnt_step = 0;
        run_frames(2);
        check("release_early", 32'(cnt_step), 32'd0);
        run_frames(1);
        check("release_step", 32'(cnt_step), 32'd1);
        check("release_rot", 32'(rot_counter), 32'd14);

        // Drop enable during digit 2 drive.
        repeat (2 * R + B) tick();
        check("dig2_an", 32'(an), 32'hB);
        cnt_fd   = 0;
        cnt_step = 0;
        enable   = 1'b0;
        tick();
        check("drop_an", 32'(an), 32'hF);
        check("drop_sel", 32'(regSel), 32'h0);
        repeat (2) tick();
        check("drop_no_fd", 32'(cnt_fd), 32'd0);
        check("drop_no_step", 32'(cnt_step), 32'd0);
        enable = 1'b1;
        repeat (B + 1) tick();
        check("resume_an", 32'(an), 32'hE);
        check("resume_rot", 32'(rot_counter), 32'd14);

        // Async reset in the middle of a drive slot with offset 5.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        dir = 1'b0;
        tick();
        run_frames(15);
        check("pre_reset_rot", 32'(rot_counter), 32'd5);
        repeat (R + B) tick();
        check("pre_reset_an", 32'(an), 32'hD);
        #3;
        reset = 1'b1;
        #1;
        check("async_rot", 32'(rot_counter), 32'h0);
        check("async_sel", 32'(regSel), 32'h0);
        check("async_an", 32'(an), 32'hF);
        check("async_fd", 32'(frame_done), 32'h0);
        check("async_step", 32'(step), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (B + 2) tick();
        check("post_reset_an", 32'(an), 32'hE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
